// File: rtl/mips_prog_loader.sv
// Streams a program image into instruction memory, then releases the processor from hold.
// Define LOADER_CHECKSUM_EN to add a running 32-bit sum of the loaded words on port checksum.
module mips_prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   input  logic              cpu_halted,
   output logic [ADDR_W:0]   words_loaded,
`ifdef LOADER_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, ERR} state_t;

   state_t            state, state_nxt;
   logic              out_of_rst;
   logic [ADDR_W-1:0] ptr;
   logic              xfer;
   logic              vld_p0;
   logic              image_done;

   // The pointer stops at the top of memory; the FSM decides between START and ERR there.
   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == PTR_MAX) ? p : p + ADDR_W'(1);
   endfunction

   assign in_ready   = out_of_rst && (state == IDLE || state == LOAD);
   assign xfer       = in_valid && in_ready;
   assign vld_p0     = xfer && !clear;
   assign image_done = (state == RUN) && cpu_halted;

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         out_of_rst <= 1'b0;
      end else begin
         state      <= state_nxt;
         out_of_rst <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cpu_hold  = 1'b1;
      cpu_start = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (xfer) begin
               if (in_last)
                  state_nxt = START;
               else if (ptr == PTR_MAX)
                  state_nxt = ERR;
               else
                  state_nxt = LOAD;
            end
         end
         START: begin
            cpu_hold  = 1'b0;
            cpu_start = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            cpu_hold = 1'b0;
            if (cpu_halted)
               state_nxt = IDLE;
         end
         ERR: begin
            err = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear)
         state_nxt = IDLE;
   end

   // ---- p0: registered memory write port, one cycle after the accepted transfer ----
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         ptr          <= BASE_PTR;
         words_loaded <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= BASE_PTR;
         mem_wdata    <= '0;
      end else begin
         mem_we <= vld_p0;
         if (vld_p0) begin
            mem_addr  <= ptr;
            mem_wdata <= in_data;
         end
         if (clear || image_done) begin
            ptr          <= BASE_PTR;
            words_loaded <= '0;
         end else if (vld_p0) begin
            ptr          <= ptr_inc(ptr);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk1 or posedge reset) begin
      if (reset)
         checksum <= '0;
      else if (clear || image_done)
         checksum <= '0;
      else if (vld_p0)
         checksum <= checksum + in_data;
   end
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: stimulus queues expected memory writes, a monitor checks them.
module tb_mips_prog_loader;

   localparam int AW = 4;

   logic          clk1 = 1'b0;
   logic          reset, in_valid, in_last, in_ready, clear;
   logic          mem_we, cpu_hold, cpu_start, cpu_halted, err;
   logic [31:0]   in_data, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   words_loaded;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int checks = 0;
   int passes = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          start;
   } wr_t;

   wr_t exp_q[$];

   logic [31:0] fact [11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                              32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                              32'h3460fffc, 32'h2542fffe, 32'hfc000000};
   logic [31:0] ck_img [3] = '{32'h00000001, 32'h00000002, 32'hFFFFFFFF};

   mips_prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk1        (clk1),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .clear       (clear),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_hold    (cpu_hold),
      .cpu_start   (cpu_start),
      .cpu_halted  (cpu_halted),
      .words_loaded(words_loaded),
`ifdef LOADER_CHECKSUM_EN
      .checksum    (checksum),
`endif
      .err         (err)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req)
         passes++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   // Drive one word and wait (bounded) for acceptance.
   task automatic send(input logic [31:0] d, input logic last, output bit acc);
      int n;
      acc = 1'b0;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      chk("hold_while_loading", 32'(cpu_hold), 32'd1);
      while (!in_ready && n < 8) begin
         tick();
         n++;
      end
      if (in_ready) begin
         tick();
         acc = 1'b1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // mode 0: factorial image, 1: counting pattern, 2: checksum image
   task automatic load(input int n, input int mode, input bit gaps, input bit last_on_final);
      bit          acc;
      bit          fin;
      logic [31:0] d;
      wr_t         w;
      for (int i = 0; i < n; i++) begin
         if (mode == 0)
            d = fact[i];
         else if (mode == 2)
            d = ck_img[i];
         else
            d = 32'hC0DE0000 | 32'(i);
         fin     = last_on_final && (i == n - 1);
         w.addr  = AW'(i);
         w.data  = d;
         w.start = fin;
         exp_q.push_back(w);
         send(d, fin, acc);
         chk("word_accepted", 32'(acc), 32'd1);
         if (gaps && i != n - 1)
            tick();
      end
   endtask

   // Called in the START cycle; walks through RUN and back to IDLE via cpu_halted.
   task automatic run_and_halt(input int n);
      chk("start_pulse", 32'(cpu_start), 32'd1);
      chk("start_hold", 32'(cpu_hold), 32'd0);
      chk("start_ready", 32'(in_ready), 32'd0);
      chk("start_words", 32'(words_loaded), 32'(n));
      tick();
      chk("run_start_low", 32'(cpu_start), 32'd0);
      chk("run_hold", 32'(cpu_hold), 32'd0);
      tick();
      chk("run_stays", 32'(cpu_hold), 32'd0);
      cpu_halted = 1'b1;
      tick();
      cpu_halted = 1'b0;
      chk("halt_hold", 32'(cpu_hold), 32'd1);
      chk("halt_words", 32'(words_loaded), 32'd0);
      chk("halt_ready", 32'(in_ready), 32'd1);
   endtask

   always @(negedge clk1) begin
      wr_t e;
      if (!reset) begin
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: addr=0x%0h data=0x%08h, expected no write", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (mem_addr === e.addr && mem_wdata === e.data && cpu_start === e.start)
                  passes++;
               else
                  $display("FAIL mem_write: got addr=0x%0h data=0x%08h start=%0b, expected addr=0x%0h data=0x%08h start=%0b",
                           mem_addr, mem_wdata, cpu_start, e.addr, e.data, e.start);
            end
         end else if (cpu_start) begin
            checks++;
            $display("FAIL start_without_write: got cpu_start=1, expected 0 with no write");
         end
      end
   end

   initial begin
      bit acc;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      clear = 1'b0; cpu_halted = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_start", 32'(cpu_start), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      chk("ready_before_edge", 32'(in_ready), 32'd0);
      tick();
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      load(11, 0, 1'b0, 1'b1);
      run_and_halt(11);

      load(11, 0, 1'b1, 1'b1);
      run_and_halt(11);

      load(5, 0, 1'b0, 1'b0);
      tick();
      chk("partial_words", 32'(words_loaded), 32'd5);
      reset = 1'b1;
      #1;
      chk("async_rst_addr", 32'(mem_addr), 32'd0);
      chk("async_rst_words", 32'(words_loaded), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd0);
      chk("async_rst_hold", 32'(cpu_hold), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      load(11, 0, 1'b0, 1'b1);
      run_and_halt(11);

      in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1; clear = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
      chk("clear_drop_we", 32'(mem_we), 32'd0);
      chk("clear_drop_start", 32'(cpu_start), 32'd0);
      chk("clear_drop_words", 32'(words_loaded), 32'd0);

      load(3, 1, 1'b0, 1'b0);
      chk("midload_words", 32'(words_loaded), 32'd3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("midclear_words", 32'(words_loaded), 32'd0);
      chk("midclear_ready", 32'(in_ready), 32'd1);

      load(1, 1, 1'b0, 1'b1);
      run_and_halt(1);

      load(16, 1, 1'b0, 1'b1);
      chk("full_no_err", 32'(err), 32'd0);
      run_and_halt(16);

      load(16, 1, 1'b0, 1'b0);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_ready", 32'(in_ready), 32'd0);
      chk("ovf_hold", 32'(cpu_hold), 32'd1);
      chk("ovf_words", 32'(words_loaded), 32'd16);
      send(32'h0BAD0BAD, 1'b1, acc);
      chk("ovf_reject", 32'(acc), 32'd0);
      chk("ovf_err_sticky", 32'(err), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("ovf_clear_err", 32'(err), 32'd0);
      chk("ovf_clear_ready", 32'(in_ready), 32'd1);
      chk("ovf_clear_words", 32'(words_loaded), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      load(3, 2, 1'b0, 1'b1);
      chk("checksum_start", checksum, 32'h00000002);
      run_and_halt(3);
      chk("checksum_cleared", checksum, 32'h00000000);
`endif

      tick();
      tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
